// File: rtl/ifetch_unit.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer, PC and retired-instruction
// counter, loadable instruction memory with a combinational read port, and
// field split of the current instruction word for the decoder.
module ifetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Zero,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic              valid,
  output logic [31:0]       icount,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] icount_q, icount_d;
  logic [31:0] mem [DEPTH];
  logic [31:0] pc4, br_off, npc;

  // Combinational fetch; upper PC bits alias onto the memory, byte offset ignored.
  assign instr = mem[pc_q[ADDR_W+1:2]];
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign imm16 = instr[15:0];
  assign func  = instr[5:0];
  assign pc     = pc_q;
  assign icount = icount_q;

  // Next-PC select: jump beats taken branch beats sequential.
  always_comb begin
    pc4    = pc_q + 32'd4;
    br_off = {{14{imm16[15]}}, imm16, 2'b00};
    if (Jump)
      npc = {pc4[31:28], instr[25:0], 2'b00};
    else if (Branch && Zero)
      npc = pc4 + br_off;
    else
      npc = pc4;
  end

  // Loads only land while the core is not executing.
  always_ff @(posedge clk) begin
    if (ld_en && state_q != RUN)
      mem[ld_addr] <= ld_data;
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= PC_RESET;
      icount_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
    end
  end

  // Sequencer: retire one instruction per unstalled RUN cycle; the halt
  // opcode parks the PC on itself without being counted.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    valid    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          pc_d     = PC_RESET;
          icount_d = 32'd0;
        end
      end
      RUN: begin
        valid = 1'b1;
        if (!stall) begin
          if (op == 6'b111111) begin
            state_d = HALT;
          end else begin
            pc_d     = npc;
            icount_d = icount_q + 32'd1;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d  = RUN;
          pc_d     = PC_RESET;
          icount_d = 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: each task drives one scenario and checks
// hand-computed PC, counter and status values.
module tb_ifetch_unit;

  localparam logic [31:0] ADD  = 32'h0022_1820;  // add rd=3, rs=1, rt=2
  localparam logic [31:0] HLT  = 32'hFC00_0000;
  localparam logic [31:0] BEQ  = 32'h1000_FFFE;

  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0, stall = 0, Branch = 0, Jump = 0, Zero = 0;
  logic        ld_en = 0;
  logic [7:0]  ld_addr = 0;
  logic [31:0] ld_data = 0;
  logic [31:0] pc, instr, icount;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        valid, halted;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.ADDR_W(8), .PC_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .Branch(Branch), .Jump(Jump), .Zero(Zero),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .pc(pc), .instr(instr), .op(op), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .valid(valid), .icount(icount), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 0;
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    #2;
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc); end
    checks++; if (valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: valid %b halted %b exp 0 0", valid, halted); end
    checks++; if (icount !== 32'h0) begin errors++; $display("FAIL reset_icount: got %h exp 0", icount); end
    reset = 0;
    tick();
    tick();
    checks++; if (valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL idle_hold: valid %b pc %h exp 0 0", valid, pc); end
  endtask

  task automatic test_sequential();
    load(0, ADD); load(1, ADD); load(2, ADD); load(3, HLT);
    go();
    checks++; if (pc !== 32'h0 || valid !== 1'b1) begin errors++; $display("FAIL seq_first: pc %h valid %b exp 0 1", pc, valid); end
    checks++; if (op !== 6'h00 || rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3 || func !== 6'h20)
      begin errors++; $display("FAIL seq_fields: op %h rs %0d rt %0d rd %0d func %h exp 00 1 2 3 20", op, rs, rt, rd, func); end
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h exp 4", pc); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h exp 8", pc); end
    tick();
    checks++; if (pc !== 32'hC || op !== 6'h3F || icount !== 32'd3) begin errors++; $display("FAIL seq_pcC: pc %h op %h icount %0d exp c 3f 3", pc, op, icount); end
    tick();
    checks++; if (halted !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL seq_halt: halted %b valid %b exp 1 0", halted, valid); end
    tick();
    checks++; if (pc !== 32'hC || icount !== 32'd3) begin errors++; $display("FAIL seq_hold: pc %h icount %0d exp c 3", pc, icount); end
  endtask

  task automatic test_branch();
    load(3, ADD); load(4, BEQ); load(5, HLT);
    go();
    repeat (4) tick();
    checks++; if (pc !== 32'h10 || imm16 !== 16'hFFFE) begin errors++; $display("FAIL br_at10: pc %h imm %h exp 10 fffe", pc, imm16); end
    Branch = 1; Zero = 1;
    tick();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL br_taken: got %h exp c", pc); end
    Branch = 0; Zero = 0;
    tick();
    Branch = 1; Zero = 0;
    tick();
    Branch = 0;
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL br_not_taken: got %h exp 14", pc); end
    tick();
    checks++; if (halted !== 1'b1 || pc !== 32'h14 || icount !== 32'd7) begin errors++; $display("FAIL br_end: halted %b pc %h icount %0d exp 1 14 7", halted, pc, icount); end
  endtask

  task automatic test_jump();
    load(8'h00, 32'h0800_0008); load(8'h08, 32'h0800_0040); load(8'h40, HLT);
    go();
    Jump = 1;
    tick();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL jmp_20: got %h exp 20", pc); end
    Branch = 1; Zero = 1;
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jmp_prio: got %h exp 100", pc); end
    Jump = 0; Branch = 0; Zero = 0;
    tick();
    checks++; if (halted !== 1'b1 || icount !== 32'd2) begin errors++; $display("FAIL jmp_end: halted %b icount %0d exp 1 2", halted, icount); end
    Jump = 1; Branch = 1; Zero = 1;
    tick();
    Jump = 0; Branch = 0; Zero = 0;
    checks++; if (pc !== 32'h100 || halted !== 1'b1) begin errors++; $display("FAIL jmp_ignored_halt: pc %h halted %b exp 100 1", pc, halted); end
  endtask

  task automatic test_stall();
    load(0, ADD); load(1, ADD); load(2, ADD); load(3, ADD); load(4, HLT);
    go();
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h8 || icount !== 32'd2 || valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold%0d: pc %h icount %0d valid %b exp 8 2 1", i, pc, icount, valid); end
    end
    stall = 0;
    tick();
    checks++; if (pc !== 32'hC || icount !== 32'd3) begin errors++; $display("FAIL stall_release: pc %h icount %0d exp c 3", pc, icount); end
    tick(); tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stall_end: halted %b exp 1", halted); end
  endtask

  task automatic test_reset_midrun();
    load(8'h00, 32'h0800_0010); load(8'h10, ADD);
    go();
    Jump = 1;
    tick();
    Jump = 0;
    checks++; if (pc !== 32'h40 || valid !== 1'b1) begin errors++; $display("FAIL mid_at40: pc %h valid %b exp 40 1", pc, valid); end
    #2 reset = 1;
    #1;
    checks++; if (pc !== 32'h0 || valid !== 1'b0 || halted !== 1'b0 || icount !== 32'h0)
      begin errors++; $display("FAIL mid_async: pc %h valid %b halted %b icount %0d exp 0 0 0 0", pc, valid, halted, icount); end
    #1 reset = 0;
    tick();
    checks++; if (instr !== 32'h0800_0010 || valid !== 1'b0) begin errors++; $display("FAIL mid_mem_kept: instr %h valid %b exp 08000010 0", instr, valid); end
    go();
    Jump = 1;
    tick();
    Jump = 0;
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL mid_rerun: got %h exp 40", pc); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    load(8'h00, 32'h0800_00FF); load(8'hFF, ADD);
    go();
    Jump = 1;
    tick();
    Jump = 0;
    checks++; if (pc !== 32'h3FC || instr !== ADD) begin errors++; $display("FAIL wrap_3fc: pc %h instr %h exp 3fc %h", pc, instr, ADD); end
    tick();
    checks++; if (pc !== 32'h400 || instr !== 32'h0800_00FF) begin errors++; $display("FAIL wrap_alias: pc %h instr %h exp 400 080000ff", pc, instr); end
    load(8'h00, HLT);
    pulse_reset();
    checks++; if (instr !== 32'h0800_00FF) begin errors++; $display("FAIL run_load_ignored: instr %h exp 080000ff", instr); end
  endtask

  task automatic test_start_load();
    ld_en = 1; ld_addr = 0; ld_data = HLT; start = 1;
    tick();
    ld_en = 0; start = 0;
    checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== HLT) begin errors++; $display("FAIL sl_first: valid %b pc %h instr %h exp 1 0 fc000000", valid, pc, instr); end
    tick();
    checks++; if (halted !== 1'b1 || icount !== 32'd0 || pc !== 32'h0) begin errors++; $display("FAIL sl_halt: halted %b icount %0d pc %h exp 1 0 0", halted, icount, pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_reset_midrun();
    test_wrap();
    test_start_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
